vmask_popc_accum: RTL and testbench

Multi-beat accumulator for mask-reduction instructions (vcpop.m, vfirst.m) in the vector permutation unit. It sits directly downstream of the 32:2 population-count compressor. Each beat it consumes the compressor's two 6-bit carry-save vectors together with the raw 32-bit mask chunk that produced them. Over one mask register it accumulates a full population count and the index of the first set bit, then hands one scalar result to writeback through a valid/ready handshake.

---
 rtl/vmask_popc_accum_pkg.sv | 22 ++
 rtl/vmask_popc_accum_ctz32.sv | 22 ++
 rtl/vmask_popc_accum.sv | 143 ++++++++++++++
 tb/tb_vmask_popc_accum.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vmask_popc_accum_pkg.sv
// Shared types for the mask-reduction accumulator: chunk width, carry-save pair
// and FSM state encoding.
package vmask_popc_accum_pkg;

  localparam int MASK_CHUNK = 32;
  localparam int CS_W       = 6;
  localparam int BEAT_SUM_W = 7;

  typedef logic [1:0][CS_W-1:0] cs_pair_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } popc_state_t;

  // Resolve the compressor's carry-save pair into a 0..32 beat count.
  function automatic logic [BEAT_SUM_W-1:0] beat_sum(input cs_pair_t cs);
    return {1'b0, cs[0]} + {1'b0, cs[1]};
  endfunction

endpackage

// File: rtl/vmask_popc_accum_ctz32.sv
// Combinational count-trailing-zeros over one 32-bit mask chunk.
// o_idx is the lowest set bit position; o_zero flags an all-zero chunk.
module vmask_popc_accum_ctz32
  import vmask_popc_accum_pkg::*;
(
  input  logic [MASK_CHUNK-1:0] i_vec,
  output logic [4:0]            o_idx,
  output logic                  o_zero
);

  always_comb begin
    o_idx  = '0;
    o_zero = ~|i_vec;
    // Scan downward so the lowest set bit is the one left standing.
    for (int i = MASK_CHUNK - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = 5'(i);
      end
    end
  end

endmodule

// File: rtl/vmask_popc_accum.sv
// Multi-beat vcpop.m / vfirst.m accumulator: sums carry-save beat counts and
// tracks the first set bit, then presents one registered result via valid/ready.
module vmask_popc_accum
  import vmask_popc_accum_pkg::*;
#(
  parameter int VLEN  = 256,
  parameter int BEATS = VLEN / MASK_CHUNK,
  parameter int CNT_W = $clog2(VLEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0][CS_W-1:0]  in_cs,
  input  logic [MASK_CHUNK-1:0] in_mask,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      out_count,
  output logic [CNT_W-1:0]      out_first
);

  localparam int IDX_W = $clog2(BEATS) + 1;

  popc_state_t      r_state;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_first;
  logic             r_found;
  logic [IDX_W-1:0] r_beat_idx;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_out_count;
  logic [CNT_W-1:0] r_out_first;

  popc_state_t      w_state_nxt;
  logic [CNT_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_first_nxt;
  logic             w_found_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] w_ocnt_nxt;
  logic [CNT_W-1:0] w_ofirst_nxt;

  logic                  w_accept;
  logic                  w_at_limit;
  logic [BEAT_SUM_W-1:0] w_beat_sum;
  logic [4:0]            w_ctz;
  logic                  w_zero;
  logic [CNT_W-1:0]      w_first_cand;

  vmask_popc_accum_ctz32 u_ctz (
    .i_vec  (in_mask),
    .o_idx  (w_ctz),
    .o_zero (w_zero)
  );

  // in_ready is a register so it is low through reset and never sees in_valid.
  assign w_accept     = in_valid && r_in_ready;
  assign w_at_limit   = (r_beat_idx == IDX_W'(BEATS - 1));
  assign w_beat_sum   = beat_sum(in_cs);
  assign w_first_cand = (CNT_W'(r_beat_idx) << 5) | CNT_W'(w_ctz);

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_first_nxt  = r_first;
    w_found_nxt  = r_found;
    w_idx_nxt    = r_beat_idx;
    w_ocnt_nxt   = r_out_count;
    w_ofirst_nxt = r_out_first;

    if (flush) begin
      w_state_nxt  = ST_IDLE;
      w_acc_nxt    = '0;
      w_first_nxt  = '0;
      w_found_nxt  = 1'b0;
      w_idx_nxt    = '0;
      w_ocnt_nxt   = '0;
      w_ofirst_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_accept) begin
            w_acc_nxt = r_acc + CNT_W'(w_beat_sum);
            w_idx_nxt = r_beat_idx + IDX_W'(1);
            if (!r_found && !w_zero) begin
              w_first_nxt = w_first_cand;
              w_found_nxt = 1'b1;
            end
            if (in_last || w_at_limit) begin
              w_state_nxt  = ST_DONE;
              w_ocnt_nxt   = w_acc_nxt;
              w_ofirst_nxt = w_found_nxt ? w_first_nxt : '1;
            end else begin
              w_state_nxt = ST_ACCUM;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            w_state_nxt  = ST_IDLE;
            w_acc_nxt    = '0;
            w_first_nxt  = '0;
            w_found_nxt  = 1'b0;
            w_idx_nxt    = '0;
            w_ocnt_nxt   = '0;
            w_ofirst_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_first     <= '0;
      r_found     <= 1'b0;
      r_beat_idx  <= '0;
      r_in_ready  <= 1'b0;
      r_out_count <= '0;
      r_out_first <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_first     <= w_first_nxt;
      r_found     <= w_found_nxt;
      r_beat_idx  <= w_idx_nxt;
      r_in_ready  <= (w_state_nxt != ST_DONE);
      r_out_count <= w_ocnt_nxt;
      r_out_first <= w_ofirst_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign out_count = r_out_count;
  assign out_first = r_out_first;

endmodule

// File: tb/tb_vmask_popc_accum.sv
// Bench for vmask_popc_accum: directed scenarios with literal expectations plus
// randomized operations checked every cycle against a per-operation reference model.
module tb_vmask_popc_accum;
  import vmask_popc_accum_pkg::*;

  localparam int VLEN  = 256;
  localparam int BEATS = VLEN / 32;
  localparam int CNT_W = $clog2(VLEN) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0][5:0]  in_cs = '0;
  logic [31:0]      in_mask = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_first;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vmask_popc_accum #(.VLEN(VLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cs     (in_cs),
    .in_mask   (in_mask),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_first (out_first)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: one operation = the list of accepted beats since the last
  // clear; the result is the plain sum of beat counts and the global first-one index.
  int m_cnt = 0;
  int m_beats = 0;
  int m_first = -1;
  bit m_done = 1'b0;

  function automatic int first_one(input logic [31:0] m);
    for (int i = 0; i < 32; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_beats = 0; m_first = -1; m_done = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      model_clear();
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!m_done));
      chk("out_valid", 32'(out_valid), 32'(m_done));
      if (m_done) begin
        chk("out_count", 32'(out_count), 32'(m_cnt));
        chk("out_first", 32'(out_first), (m_first < 0) ? 32'h1FF : 32'(m_first));
      end
      if (flush) begin
        model_clear();
      end else if (m_done) begin
        if (out_ready) model_clear();
      end else if (in_valid) begin
        if (m_first < 0 && in_mask != 32'd0) m_first = m_beats * 32 + first_one(in_mask);
        m_cnt += int'(in_cs[0]) + int'(in_cs[1]);
        m_beats++;
        if (in_last || m_beats == BEATS) m_done = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [5:0] c0, input logic [5:0] c1,
                           input logic [31:0] m, input logic last);
    bit acc;
    in_valid = 1'b1; in_cs[0] = c0; in_cs[1] = c1; in_mask = m; in_last = last;
    for (int k = 0; k < 40; k++) begin
      acc = in_ready;
      step();
      if (acc) begin
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; n_fail++;
    $display("FAIL send_beat_timeout: in_ready never high, required 1 at %0t", $time);
  endtask

  task automatic wait_valid(input string nm);
    for (int k = 0; k < 40; k++) begin
      if (out_valid) return;
      step();
    end
    n_cmp++; n_fail++;
    $display("FAIL %s_timeout: out_valid stayed 0, required 1", nm);
  endtask

  task automatic pop(input int hold);
    repeat (hold) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pc, sel;
    bit nolast, do_flush, flushed;
    logic [31:0] m;
    logic [5:0] c0;

    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_count", 32'(out_count), 32'd0);
    chk("reset_out_first", 32'(out_first), 32'd0);
    @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;
    step();
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Single full beat.
    send_beat(6'd16, 6'd16, 32'hFFFF_FFFF, 1'b1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_count", 32'(out_count), 32'd32);
    chk("t1_first", 32'(out_first), 32'd0);
    pop(0);

    // Eight beats, single bit in beat 5 position 8.
    for (int b = 0; b < 8; b++)
      send_beat((b == 5) ? 6'd1 : 6'd0, 6'd0, (b == 5) ? 32'h0000_0100 : 32'h0, b == 7);
    chk("t2_count", 32'(out_count), 32'd1);
    chk("t2_first", 32'(out_first), 32'd168);
    pop(0);

    // All-zero operation ending early.
    for (int b = 0; b < 3; b++) send_beat(6'd0, 6'd0, 32'h0, b == 2);
    chk("t3_count", 32'(out_count), 32'd0);
    chk("t3_first", 32'(out_first), 32'h1FF);
    pop(0);

    // Beat limit without in_last, ninth beat refused while result held.
    for (int b = 0; b < 8; b++)
      send_beat((b == 0) ? 6'd1 : 6'd2, (b == 0) ? 6'd0 : 6'd2,
                (b == 0) ? 32'h0000_0010 : 32'hF000_0000, 1'b0);
    in_valid = 1'b1; in_cs[0] = 6'd5; in_cs[1] = 6'd5; in_mask = 32'h3FF;
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_ready", 32'(in_ready), 32'd0);
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_count", 32'(out_count), 32'd29);
      chk("t4_hold_first", 32'(out_first), 32'd4);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_handoff_ready", 32'(in_ready), 32'd1);
    chk("t4_handoff_valid", 32'(out_valid), 32'd0);
    send_beat(6'd1, 6'd1, 32'h3, 1'b1);
    chk("t4_next_count", 32'(out_count), 32'd2);
    pop(1);

    // Flush in the same cycle as beat 4.
    for (int b = 0; b < 3; b++) send_beat(6'd2, 6'd0, 32'h0000_0600, 1'b0);
    in_valid = 1'b1; in_cs[0] = 6'd1; in_cs[1] = 6'd0; in_mask = 32'h1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_flush_valid", 32'(out_valid), 32'd0);
    chk("t5_flush_ready", 32'(in_ready), 32'd1);
    send_beat(6'd3, 6'd2, 32'h0000_3E00, 1'b1);
    chk("t5_count", 32'(out_count), 32'd5);
    chk("t5_first", 32'(out_first), 32'd9);
    pop(0);

    // Asynchronous reset mid-operation.
    for (int b = 0; b < 3; b++) send_beat(6'd4, 6'd0, 32'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;
    step();
    send_beat(6'd2, 6'd1, 32'h7, 1'b1);
    chk("t6_count", 32'(out_count), 32'd3);
    chk("t6_first", 32'(out_first), 32'd0);
    pop(0);

    // Randomized operations with bubbles, stalls and occasional flushes.
    for (int op = 0; op < 60; op++) begin
      n = $urandom_range(1, BEATS);
      nolast = (n == BEATS) && ($urandom_range(0, 1) == 1);
      do_flush = ($urandom_range(0, 7) == 0);
      flushed = 1'b0;
      for (int b = 0; b < n && !flushed; b++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        sel = $urandom_range(0, 3);
        case (sel)
          0: m = 32'h0;
          1: m = 32'h1 << $urandom_range(0, 31);
          2: m = $urandom;
          default: m = $urandom & $urandom & $urandom;
        endcase
        pc = $countones(m);
        c0 = 6'($urandom_range(0, pc));
        if (do_flush && b == n / 2) begin
          in_valid = 1'b1; in_cs[0] = c0; in_cs[1] = 6'(pc) - c0; in_mask = m; flush = 1'b1;
          step();
          flush = 1'b0; in_valid = 1'b0;
          flushed = 1'b1;
        end else begin
          send_beat(c0, 6'(pc) - c0, m, (b == n - 1) && !nolast);
        end
      end
      if (!flushed) begin
        wait_valid("rand");
        pop($urandom_range(0, 3));
      end
    end

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
